// File: rtl/edge_event_detector.sv
// edge_event_detector
// Multi-channel edge detector. Each channel optionally synchronises its
// input, detects raw rising/falling edges, qualifies them with a per-channel
// run-time mode, stretches the qualified pulse and keeps a sticky flag that
// software clears.
// Optional feature macro: EDGE_EVENT_DETECTOR_COUNTER_EN adds a saturating
// per-channel event counter, exported on event_count.
module edge_event_detector #(
  parameter int WIDTH         = 1,
  parameter int SYNC_STAGES   = 0,
  parameter int PULSE_LENGTH  = 1,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     signal,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     flag_clear,
  output logic [WIDTH-1:0]     rising_edge,
  output logic [WIDTH-1:0]     falling_edge,
  output logic [WIDTH-1:0]     edge_pulse,
  output logic [WIDTH-1:0]     event_flag
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
  ,
  output logic [WIDTH*COUNTER_WIDTH-1:0] event_count
`endif
);

  // Stretch counter holds the remaining extra pulse cycles; never narrower
  // than one bit so PULSE_LENGTH=1 still elaborates (counter stays at 0).
  localparam int STRETCH_W = (PULSE_LENGTH > 1) ? $clog2(PULSE_LENGTH) : 1;
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(PULSE_LENGTH - 1);

  // Reject parameter values that make no sense for this block.
  if (WIDTH < 1) begin : g_bad_width
    $error("edge_event_detector: WIDTH must be at least 1");
  end
  if (PULSE_LENGTH < 1) begin : g_bad_pulse
    $error("edge_event_detector: PULSE_LENGTH must be at least 1");
  end
  if (SYNC_STAGES < 0) begin : g_bad_sync
    $error("edge_event_detector: SYNC_STAGES must not be negative");
  end
  if (COUNTER_WIDTH < 1) begin : g_bad_cnt
    $error("edge_event_detector: COUNTER_WIDTH must be at least 1");
  end

  logic [WIDTH-1:0]     sampled_s;
  logic [WIDTH-1:0]     previous_r;
  logic [WIDTH-1:0]     qual_s;
  logic [STRETCH_W-1:0] stretch_r     [WIDTH];
  logic [STRETCH_W-1:0] stretch_nxt_s [WIDTH];

  if (SYNC_STAGES > 0) begin : g_sync
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];

    // Shift every line through its synchroniser chain; last stage is sampled.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_r[s] <= {WIDTH{1'b0}};
        end
      end else begin
        sync_r[0] <= signal;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_r[s] <= sync_r[s-1];
        end
      end
    end

    assign sampled_s = sync_r[SYNC_STAGES-1];
  end else begin : g_nosync
    assign sampled_s = signal;
  end

  // Remember last cycle's sampled value for edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      previous_r <= {WIDTH{1'b0}};
    end else begin
      previous_r <= sampled_s;
    end
  end

  assign rising_edge  = sampled_s & ~previous_r;
  assign falling_edge = ~sampled_s & previous_r;

  // Qualify raw edges with the per-channel mode (bit0 rising, bit1 falling).
  always_comb begin
    qual_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      qual_s[i] = (mode[2*i] & rising_edge[i]) | (mode[2*i+1] & falling_edge[i]);
    end
  end

  // Next stretch count: reload on a qualified edge, otherwise count down to 0.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stretch_nxt_s[i] = stretch_r[i];
      if (qual_s[i]) begin
        stretch_nxt_s[i] = STRETCH_LOAD;
      end else if (stretch_r[i] != {STRETCH_W{1'b0}}) begin
        stretch_nxt_s[i] = stretch_r[i] - STRETCH_W'(1);
      end else begin
        stretch_nxt_s[i] = {STRETCH_W{1'b0}};
      end
    end
  end

  // Stretch counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WIDTH; i++) begin
        stretch_r[i] <= {STRETCH_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        stretch_r[i] <= stretch_nxt_s[i];
      end
    end
  end

  // Pulse is high in the detect cycle and while stretch cycles remain.
  always_comb begin
    edge_pulse = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      edge_pulse[i] = qual_s[i] | (stretch_r[i] != {STRETCH_W{1'b0}});
    end
  end

  // Sticky flag: a qualified edge sets it and wins over a simultaneous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      event_flag <= {WIDTH{1'b0}};
    end else begin
      event_flag <= qual_s | (event_flag & ~flag_clear);
    end
  end

`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
  logic [COUNTER_WIDTH-1:0] event_cnt_r     [WIDTH];
  logic [COUNTER_WIDTH-1:0] event_cnt_nxt_s [WIDTH];

  // Next event count: clear (or clear-and-count to 1), else saturating count.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      event_cnt_nxt_s[i] = event_cnt_r[i];
      if (flag_clear[i] && qual_s[i]) begin
        event_cnt_nxt_s[i] = COUNTER_WIDTH'(1);
      end else if (flag_clear[i]) begin
        event_cnt_nxt_s[i] = {COUNTER_WIDTH{1'b0}};
      end else if (qual_s[i] && (event_cnt_r[i] != {COUNTER_WIDTH{1'b1}})) begin
        event_cnt_nxt_s[i] = event_cnt_r[i] + COUNTER_WIDTH'(1);
      end else begin
        event_cnt_nxt_s[i] = event_cnt_r[i];
      end
    end
  end

  // Event counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WIDTH; i++) begin
        event_cnt_r[i] <= {COUNTER_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        event_cnt_r[i] <= event_cnt_nxt_s[i];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt_out
    assign event_count[g*COUNTER_WIDTH +: COUNTER_WIDTH] = event_cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_edge_event_detector.sv
// tb_edge_event_detector
// Directed bench for edge_event_detector using three configurations:
//   u0: WIDTH=2, SYNC_STAGES=0, PULSE_LENGTH=1 (basic detect, flag clear)
//   u1: WIDTH=1, SYNC_STAGES=2, PULSE_LENGTH=1 (synchroniser, both edges)
//   u2: WIDTH=1, SYNC_STAGES=0, PULSE_LENGTH=4, COUNTER_WIDTH=2 (stretch)
// Counter checks are active when EDGE_EVENT_DETECTOR_COUNTER_EN is defined.
module tb_edge_event_detector;

  logic        clock;
  logic        resetn;

  logic [1:0]  sig0, fc0, re0, fe0, ep0, ef0;
  logic [3:0]  mode0;
  logic        sig1, fc1, re1, fe1, ep1, ef1;
  logic [1:0]  mode1;
  logic        sig2, fc2, re2, fe2, ep2, ef2;
  logic [1:0]  mode2;
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
  logic [15:0] cnt0;
  logic [7:0]  cnt1;
  logic [1:0]  cnt2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  edge_event_detector #(.WIDTH(2), .SYNC_STAGES(0), .PULSE_LENGTH(1), .COUNTER_WIDTH(8)) u0 (
    .clock(clock), .resetn(resetn), .signal(sig0), .mode(mode0), .flag_clear(fc0),
    .rising_edge(re0), .falling_edge(fe0), .edge_pulse(ep0), .event_flag(ef0)
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    , .event_count(cnt0)
`endif
  );

  edge_event_detector #(.WIDTH(1), .SYNC_STAGES(2), .PULSE_LENGTH(1), .COUNTER_WIDTH(8)) u1 (
    .clock(clock), .resetn(resetn), .signal(sig1), .mode(mode1), .flag_clear(fc1),
    .rising_edge(re1), .falling_edge(fe1), .edge_pulse(ep1), .event_flag(ef1)
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    , .event_count(cnt1)
`endif
  );

  edge_event_detector #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_LENGTH(4), .COUNTER_WIDTH(2)) u2 (
    .clock(clock), .resetn(resetn), .signal(sig2), .mode(mode2), .flag_clear(fc2),
    .rising_edge(re2), .falling_edge(fe2), .edge_pulse(ep2), .event_flag(ef2)
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    , .event_count(cnt2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value and tally it.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising clock edge.
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    sig0 = 2'b00;  mode0 = 4'b0101; fc0 = 2'b00;
    sig1 = 1'b1;   mode1 = 2'b11;   fc1 = 1'b0;
    sig2 = 1'b0;   mode2 = 2'b01;   fc2 = 1'b0;

    // Reset state (u1 input already high through reset)
    @(negedge clock);
    check_val("rst_ep0", 32'(ep0), 32'd0);
    check_val("rst_ef0", 32'(ef0), 32'd0);
    check_val("rst_re1", 32'(re1), 32'd0);
    check_val("rst_ep1", 32'(ep1), 32'd0);
    check_val("rst_ep2", 32'(ep2), 32'd0);
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    check_val("rst_cnt2", 32'(cnt2), 32'd0);
`endif
    nxt();
    nxt();

    // Release reset: u1 sees exactly one rising edge, SYNC_STAGES cycles later
    nxt();
    resetn = 1'b1;
    @(negedge clock);
    check_val("rel_re1_c0", 32'(re1), 32'd0);
    nxt();
    @(negedge clock);
    check_val("rel_re1_c1", 32'(re1), 32'd0);
    nxt();
    @(negedge clock);
    check_val("rel_re1_c2", 32'(re1), 32'd1);
    check_val("rel_fe1_c2", 32'(fe1), 32'd0);
    check_val("rel_ep1_c2", 32'(ep1), 32'd1);
    nxt();
    @(negedge clock);
    check_val("rel_re1_c3", 32'(re1), 32'd0);
    check_val("rel_ep1_c3", 32'(ep1), 32'd0);
    check_val("rel_ef1_c3", 32'(ef1), 32'd1);

    // u1 both-edge mode: toggle every 6 cycles, pulse 2 cycles after change
    for (int k = 0; k < 4; k++) begin
      nxt();
      sig1 = ~sig1;
      for (int j = 0; j < 6; j++) begin
        if (j > 0) nxt();
        @(negedge clock);
        check_val("u1_pulse", 32'(ep1), 32'(j == 2));
        check_val("u1_rise",  32'(re1), 32'((j == 2) && sig1));
        check_val("u1_fall",  32'(fe1), 32'((j == 2) && !sig1));
      end
    end

    // u0 ch0 rising-only: high for 4 cycles, single pulse, flag next cycle
    nxt();
    sig0[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) nxt();
      if (j == 4) sig0[0] = 1'b0;
      @(negedge clock);
      check_val("u0_pulse", 32'(ep0[0]), 32'(j == 0));
      check_val("u0_rise",  32'(re0[0]), 32'(j == 0));
      check_val("u0_fall",  32'(fe0[0]), 32'(j == 4));
      check_val("u0_flag",  32'(ef0[0]), 32'(j >= 1));
    end

    // u0 ch1: clear with a simultaneous edge keeps the flag; clear alone drops it
    nxt();
    sig0[1] = 1'b1;
    fc0[1]  = 1'b1;
    @(negedge clock);
    check_val("clr_ep_same", 32'(ep0[1]), 32'd1);
    check_val("clr_ef_same", 32'(ef0[1]), 32'd0);
    nxt();
    @(negedge clock);
    check_val("clr_ef_setwins", 32'(ef0[1]), 32'd1);
    nxt();
    fc0[1] = 1'b0;
    @(negedge clock);
    check_val("clr_ef_cleared", 32'(ef0), 32'd1);
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    check_val("clr_cnt0", 32'(cnt0), 32'h0001);
`endif

    // u2 stretch: rising edges at cycles 10 and 12 -> high 10..15
    for (int c = 0; c < 18; c++) begin
      nxt();
      sig2 = ((c == 10) || (c == 12)) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (c >= 8) check_val("u2_stretch", 32'(ep2), 32'((c >= 10) && (c <= 15)));
    end
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    check_val("cnt2_two", 32'(cnt2), 32'd2);
`endif

    // Three more edges: counter saturates at 3
    for (int e = 0; e < 3; e++) begin
      nxt();
      sig2 = 1'b1;
      nxt();
      sig2 = 1'b0;
    end
    @(negedge clock);
    check_val("u2_flag", 32'(ef2), 32'd1);
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    check_val("cnt2_sat", 32'(cnt2), 32'd3);
`endif

    // Clear plus edge in the same cycle: count loads 1, flag stays set
    nxt();
    sig2 = 1'b1;
    fc2  = 1'b1;
    nxt();
    sig2 = 1'b0;
    fc2  = 1'b0;
    @(negedge clock);
    check_val("u2_flag_clr_edge", 32'(ef2), 32'd1);
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    check_val("cnt2_clr_edge", 32'(cnt2), 32'd1);
`endif
    for (int w = 0; w < 4; w++) nxt();

    // Reset asserted mid-stretch clears pulse and state immediately
    sig2 = 1'b1;
    @(negedge clock);
    check_val("mid_ep2_c0", 32'(ep2), 32'd1);
    nxt();
    @(negedge clock);
    check_val("mid_ep2_c1", 32'(ep2), 32'd1);
    nxt();
    sig2   = 1'b0;
    resetn = 1'b0;
    #1;
    check_val("mid_rst_ep2", 32'(ep2), 32'd0);
    check_val("mid_rst_ef2", 32'(ef2), 32'd0);
    check_val("mid_rst_ep1", 32'(ep1), 32'd0);
    check_val("mid_rst_ef0", 32'(ef0), 32'd0);
`ifdef EDGE_EVENT_DETECTOR_COUNTER_EN
    check_val("mid_rst_cnt2", 32'(cnt2), 32'd0);
`endif

    // In reset with SYNC_STAGES=0 the pulse follows the qualified rising path
    nxt();
    sig2 = 1'b1;
    @(negedge clock);
    check_val("rst_comb_ep2", 32'(ep2), 32'd1);
    check_val("rst_comb_fe2", 32'(fe2), 32'd0);
    check_val("rst_comb_ef2", 32'(ef2), 32'd0);

    resetn = 1'b1;
    nxt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_event_detector.md
Name: edge_event_detector

Overview:
Multi-channel, parametrised edge detector. It generates a qualified pulse per channel on rising, falling or both edges, selected per channel at run time. It offers optional input synchronisation, pulse stretching and sticky event flags with software clear. It sits between raw status or interrupt lines and control logic or interrupt aggregators.

Parameters:
WIDTH, 1, number of independent channels (>=1)
SYNC_STAGES, 0, synchroniser flops per channel before detection (0 = input already synchronous)
PULSE_LENGTH, 1, cycles edge_pulse is held per qualified edge (>=1)
COUNTER_WIDTH, 8, width of each per-channel event counter (used only with the optional feature)

Ports:
clock  input  1  clock; all state is on its rising edge
resetn  input  1  asynchronous, active-low reset
signal  input  WIDTH  monitored lines, one per channel
mode  input  2*WIDTH  per-channel mode, channel i at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
flag_clear  input  WIDTH  per-channel sticky-flag clear, level-sampled each cycle
rising_edge  output  WIDTH  raw rising-edge detect, independent of mode
falling_edge  output  WIDTH  raw falling-edge detect, independent of mode
edge_pulse  output  WIDTH  mode-qualified, stretched event pulse
event_flag  output  WIDTH  sticky flag, set on each qualified edge
event_count  output  WIDTH*COUNTER_WIDTH  present only with the optional feature; channel i at [i*CW+:CW]

Behaviour:
- Synchroniser: per channel, a SYNC_STAGES-deep shift register of flops, reset to 0. Its last stage is "sampled". With SYNC_STAGES=0, sampled = signal (combinational).
- Detection: previous <= sampled each cycle; previous resets to 0.
  - rising_edge = sampled & ~previous.
  - falling_edge = ~sampled & previous.
  - Consequence: a line already high at reset release produces one rising_edge. No falling_edge is produced at reset release.
- Latency from a signal transition to the raw detect: SYNC_STAGES cycles (0 = same cycle).
- Qualified edge: qual[i] = (mode bit 0 & rising_edge[i]) | (mode bit 1 & falling_edge[i]). mode is used combinationally, so a change takes effect the same cycle.
- Stretch counter per channel, width clog2(PULSE_LENGTH), minimum 1 bit.
  - On qual: load PULSE_LENGTH-1.
  - Otherwise: decrement if non-zero.
  - edge_pulse = qual | (count != 0). Each qualified edge therefore gives exactly PULSE_LENGTH high cycles, starting in the detect cycle.
- Retrigger: a qual during an active stretch reloads the counter. The pulse stays high continuously for PULSE_LENGTH cycles after the latest qualified edge.
- PULSE_LENGTH=1: the counter is always 0; edge_pulse = qual.
- Mode set to 00 during a stretch: no new qualification; the active stretch runs to completion.
- event_flag register:
  - set on qual, else cleared on flag_clear;
  - qual and flag_clear in the same cycle: flag stays/becomes 1 (set wins).
  - Visible one cycle after the qualified edge.
- Channels are fully independent; no cross-channel state.
- Reset values (asynchronous, immediate on resetn low, including mid-stretch):
  - sync flops, previous, counters, event_flag, event_count all 0;
  - edge_pulse = 0 when SYNC_STAGES>0; when SYNC_STAGES=0 it follows the combinational path: qualified rising_edge only (previous is 0, so no falling edge).

Optional Feature:
EDGE_EVENT_DETECTOR_COUNTER_EN
- Defined:
  - Per-channel COUNTER_WIDTH-bit counter increments on qual and saturates at all-ones (no wrap).
  - flag_clear resets it to 0. flag_clear with a simultaneous qual loads 1.
  - event_count is exported.
- Undefined: no counters and no event_count port; all other behaviour is identical.

Test Plan:
- WIDTH=1, SYNC_STAGES=0, PULSE_LENGTH=1, mode=01; signal 0->1 at cycle 5, held for 4 cycles, then 0 -> edge_pulse=1 only in cycle 5; event_flag=1 from cycle 6; no pulse on the falling edge.
- mode=11, SYNC_STAGES=2; toggle signal every 6 cycles -> edge_pulse on both edges, each exactly 2 cycles after the input change; rising_edge and falling_edge each assert on their own edges.
- PULSE_LENGTH=4, mode=01; rising edges at cycles 10 and 12 -> edge_pulse high continuously from cycle 10 to cycle 15 inclusive, then 0.
- Assert flag_clear in the same cycle as a qualified edge -> event_flag stays 1; flag_clear alone in the next cycle -> event_flag=0 in the following cycle.
- signal held high through reset, resetn released at cycle 3 -> rising_edge=1 for one cycle (after SYNC_STAGES); resetn pulsed low mid-stretch -> edge_pulse and counters 0 immediately.
- With EDGE_EVENT_DETECTOR_COUNTER_EN and COUNTER_WIDTH=2: 5 qualified edges -> event_count=3 (saturated); flag_clear plus an edge in the same cycle -> event_count=1.
